// File: rtl/conv_sched.sv
// Conv datapath sequencer: counts operand cachelines, issues buffer reads once both
// operands are resident, and aligns result-buffer writes to the fixed datapath latency.
module conv_sched #(
   parameter int ADDR_W       = 8,
   parameter int BUFFER_DEPTH = 256,
   parameter int MIN_CL_COUNT = 12,
   parameter int RD_LAT       = 1,
   parameter int PIPE_LAT     = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   num_lines,
   input  logic              abort,
   input  logic              cl_wr_valid,
   input  logic              buffer_select,
   input  logic              done_ack,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              issue_valid,
   output logic              res_wr_en,
   output logic [ADDR_W-1:0] res_wr_addr,
   output logic              busy,
   output logic              done,
   output logic [15:0]       stall_count
);
   localparam int LAT   = RD_LAT + PIPE_LAT;
   localparam int CNT_W = ADDR_W + 1;
   localparam int IFL_W = $clog2(LAT + 1);
   localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_CL_COUNT);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUFFER_DEPTH);

   typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} state_t;
   state_t state, state_nxt;

   logic [CNT_W-1:0]         len_q, data_cnt, wt_cnt, rd_ptr, thr;
   logic [LAT:1]             vld_pipe;
   logic [LAT:1][ADDR_W-1:0] addr_pipe;
   logic [IFL_W-1:0]         in_flight;
   logic                     counting, job_start;

   assign thr         = (len_q < MIN_CNT) ? len_q : MIN_CNT;
   assign counting    = (state == FILL) || (state == RUN) || (state == DRAIN);
   assign job_start   = (state == IDLE) && start && !abort;
   assign issue_valid = (state == RUN) && (rd_ptr < data_cnt) && (rd_ptr < wt_cnt);
   assign in_flight   = IFL_W'($countones(vld_pipe));

   assign rd_addr     = rd_ptr[ADDR_W-1:0];
   assign res_wr_en   = vld_pipe[LAT];
   assign res_wr_addr = addr_pipe[LAT];
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (num_lines == '0) ? DONE : FILL;
         FILL:    if (data_cnt >= thr && wt_cnt >= thr) state_nxt = RUN;
         RUN:     if (issue_valid && rd_ptr == len_q - CNT_W'(1)) state_nxt = DRAIN;
         // leave DRAIN as the final result retires, so DONE follows it directly
         DRAIN:   if (in_flight == IFL_W'(res_wr_en)) state_nxt = DONE;
         DONE:    if (done_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         len_q       <= '0;
         data_cnt    <= '0;
         wt_cnt      <= '0;
         rd_ptr      <= '0;
         stall_count <= '0;
      end else begin
         state <= state_nxt;
         if (job_start) begin
            len_q       <= (num_lines > DEPTH_CNT) ? DEPTH_CNT : num_lines;
            data_cnt    <= '0;
            wt_cnt      <= '0;
            rd_ptr      <= '0;
            stall_count <= '0;
         end else begin
            if (counting && cl_wr_valid && !buffer_select && data_cnt < len_q)
               data_cnt <= data_cnt + CNT_W'(1);
            if (counting && cl_wr_valid && buffer_select && wt_cnt < len_q)
               wt_cnt <= wt_cnt + CNT_W'(1);
            if (issue_valid)
               rd_ptr <= rd_ptr + CNT_W'(1);
            else if (state == RUN && stall_count != 16'hFFFF)
               stall_count <= stall_count + 16'd1;
         end
      end
   end

   // fixed-latency tracker: position in the shift register is the op's age
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe  <= '0;
         addr_pipe <= '0;
      end else begin
         vld_pipe[1]  <= issue_valid && !abort;
         addr_pipe[1] <= rd_ptr[ADDR_W-1:0];
         for (int k = 2; k <= LAT; k++) begin
            vld_pipe[k]  <= vld_pipe[k-1] && !abort;
            addr_pipe[k] <= addr_pipe[k-1];
         end
      end
   end
endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched: per-scenario tasks against a write-schedule
// driven reference model of issue times, result timing and stall count.
`timescale 1ns/1ps
module tb_conv_sched;
   localparam int LAT  = 13;
   localparam int MAXC = 3000;

   logic        clk = 1'b0;
   logic        reset, start, abort, cl_wr_valid, buffer_select, done_ack;
   logic [8:0]  num_lines;
   logic [7:0]  rd_addr, res_wr_addr;
   logic        issue_valid, res_wr_en, busy, done;
   logic [15:0] stall_count;

   int checks = 0;
   int failures = 0;
   int sched [MAXC+1];     // per cycle of a job: 0 idle, 1 data write, 2 weight write
   int exp_issue [256];
   int exp_run, exp_done, exp_stall;

   conv_sched dut (
      .clk(clk), .reset(reset), .start(start), .num_lines(num_lines), .abort(abort),
      .cl_wr_valid(cl_wr_valid), .buffer_select(buffer_select), .done_ack(done_ack),
      .rd_addr(rd_addr), .issue_valid(issue_valid), .res_wr_en(res_wr_en),
      .res_wr_addr(res_wr_addr), .busy(busy), .done(done), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void clear_sched();
      foreach (sched[i]) sched[i] = 0;
   endfunction

   function automatic void build_seq(input int n, input bit data_first);
      clear_sched();
      for (int i = 0; i < n; i++) begin
         sched[1+i]   = data_first ? 1 : 2;
         sched[1+n+i] = data_first ? 2 : 1;
      end
   endfunction

   // random gaps and interleave, two surplus writes per buffer to exercise saturation
   function automatic void build_rand(input int n);
      int nd = 0, nw = 0, c = 1;
      clear_sched();
      while ((nd < n + 2 || nw < n + 2) && c < MAXC) begin
         if ($urandom_range(3) != 0) begin
            if (nd < n + 2 && (nw >= n + 2 || $urandom_range(1) == 0)) begin
               sched[c] = 1; nd++;
            end else begin
               sched[c] = 2; nw++;
            end
         end
         c++;
      end
   endfunction

   // Cycle 0 carries start. A write in cycle c is visible to issue from c+1.
   // Address a issues at the earliest cycle that is in RUN, after issue a-1,
   // and after the (a+1)-th line of both operands has landed.
   function automatic void model(input int n);
      int wd[$], ww[$];
      int thr, t;
      for (int c = 1; c <= MAXC; c++) begin
         if (sched[c] == 1) wd.push_back(c);
         else if (sched[c] == 2) ww.push_back(c);
      end
      thr = (n < 12) ? n : 12;
      exp_run = ((wd[thr-1] > ww[thr-1]) ? wd[thr-1] : ww[thr-1]) + 2;
      for (int a = 0; a < n; a++) begin
         t = (a == 0) ? exp_run : exp_issue[a-1] + 1;
         if (wd[a] + 1 > t) t = wd[a] + 1;
         if (ww[a] + 1 > t) t = ww[a] + 1;
         exp_issue[a] = t;
      end
      exp_done  = exp_issue[n-1] + LAT + 1;
      exp_stall = exp_issue[n-1] - exp_run + 1 - n;
   endfunction

   task automatic idle_inputs();
      start = 0; abort = 0; cl_wr_valid = 0; buffer_select = 0; done_ack = 0;
   endtask

   // abort_ofs < 0: run to done and acknowledge; otherwise abort that many cycles after the last issue
   task automatic run_job(input int n, input int abort_ofs, input string tag);
      int n_iss = 0, n_res = 0, done_cyc = -1, abort_at = -1, stop = MAXC, ec;
      model(n);
      if (abort_ofs >= 0) begin
         abort_at = exp_issue[n-1] + abort_ofs;
         stop = abort_at + 20;
      end
      @(negedge clk);
      idle_inputs();
      start = 1; num_lines = 9'(n);
      for (int cyc = 1; cyc <= stop; cyc++) begin
         @(negedge clk);
         start = 0; abort = 0;
         if (issue_valid) begin
            ec = (n_iss < n) ? exp_issue[n_iss] : -1;
            checks++;
            if (cyc != ec || rd_addr !== 8'(n_iss)) begin
               failures++;
               $display("FAIL %s issue#%0d: cycle %0d addr %0d, expected cycle %0d addr %0d",
                        tag, n_iss, cyc, rd_addr, ec, n_iss);
            end
            n_iss++;
         end
         if (abort_at >= 0 && cyc > abort_at) begin
            checks++;
            if (res_wr_en !== 1'b0) begin
               failures++;
               $display("FAIL %s post_abort_res: cycle %0d res_wr_en=%b addr %0d, expected 0", tag, cyc, res_wr_en, res_wr_addr);
            end
            if (cyc == abort_at + 1) begin
               checks++;
               if (busy !== 1'b0 || done !== 1'b0) begin
                  failures++;
                  $display("FAIL %s abort_idle: busy=%b done=%b, expected 0 0", tag, busy, done);
               end
            end
         end else if (res_wr_en) begin
            ec = (n_res < n) ? exp_issue[n_res] + LAT : -1;
            checks++;
            if (cyc != ec || res_wr_addr !== 8'(n_res)) begin
               failures++;
               $display("FAIL %s result#%0d: cycle %0d addr %0d, expected cycle %0d addr %0d",
                        tag, n_res, cyc, res_wr_addr, ec, n_res);
            end
            n_res++;
         end
         if (cyc == abort_at) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || issue_valid !== 1'b0) begin
               failures++;
               $display("FAIL %s drain_at_abort: busy=%b done=%b issue=%b, expected 1 0 0", tag, busy, done, issue_valid);
            end
         end
         if (abort_at < 0 && done) begin
            done_cyc = cyc;
            break;
         end
         cl_wr_valid   = (sched[cyc] != 0) && (abort_at < 0 || cyc < abort_at);
         buffer_select = (sched[cyc] == 2);
         abort         = (cyc == abort_at);
      end
      idle_inputs();
      if (abort_at >= 0) return;
      checks++;
      if (done_cyc != exp_done || n_iss != n || n_res != n) begin
         failures++;
         $display("FAIL %s completion: done cycle %0d issues %0d results %0d, expected %0d %0d %0d",
                  tag, done_cyc, n_iss, n_res, exp_done, n, n);
      end
      checks++;
      if (stall_count !== 16'(exp_stall)) begin
         failures++;
         $display("FAIL %s stall_count: got %0d, expected %0d", tag, stall_count, exp_stall);
      end
      if (done_cyc < 0) begin
         abort = 1;
         @(negedge clk);
         abort = 0;
         return;
      end
      done_ack = 1;
      @(negedge clk);
      done_ack = 0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL %s done_ack: busy=%b done=%b, expected 0 0", tag, busy, done);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      num_lines = 0;
      reset = 1;
      repeat (3) @(negedge clk);
      checks++;
      if ({rd_addr, issue_valid, res_wr_en, res_wr_addr, busy, done, stall_count} !== '0) begin
         failures++;
         $display("FAIL reset_state: rd=%0d iv=%b we=%b wa=%0d busy=%b done=%b stall=%0d, expected all 0",
                  rd_addr, issue_valid, res_wr_en, res_wr_addr, busy, done, stall_count);
      end
      reset = 0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      build_seq(20, 1);
      run_job(20, -1, "basic20");
   endtask

   task automatic test_stall();
      clear_sched();
      for (int i = 0; i < 16; i++) sched[1+i] = 2;
      for (int i = 0; i < 16; i++) sched[17+5*i] = 1;
      run_job(16, -1, "stall16");
      checks++;
      if (stall_count == 16'd0) begin
         failures++;
         $display("FAIL stall16 nonzero: stall_count=%0d, expected > 0", stall_count);
      end
   endtask

   task automatic test_small();
      build_seq(5, 0);
      run_job(5, -1, "small5");
      build_seq(12, 1);
      run_job(12, -1, "thr12");
      build_rand(13);
      run_job(13, -1, "thr13");
   endtask

   task automatic test_zero();
      @(negedge clk);
      start = 1; num_lines = 0;
      @(negedge clk);
      start = 0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL zero_done: done=%b busy=%b, expected 1 1", done, busy);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (issue_valid !== 1'b0 || res_wr_en !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL zero_quiet: iv=%b we=%b done=%b, expected 0 0 1", issue_valid, res_wr_en, done);
         end
      end
      start = 1; done_ack = 1; num_lines = 20;
      @(negedge clk);
      start = 0; done_ack = 0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL zero_ack: busy=%b done=%b, expected 0 0", busy, done);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL start_ignored_in_done: busy=%b, expected 0", busy);
      end
      start = 1; abort = 1; num_lines = 20;
      @(negedge clk);
      idle_inputs();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_beats_start: busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_abort();
      build_seq(20, 1);
      run_job(20, 8, "abort_drain");
      build_rand(30);
      run_job(30, -1, "after_abort");
   endtask

   task automatic test_random();
      int n;
      for (int j = 0; j < 5; j++) begin
         n = $urandom_range(60, 1);
         build_rand(n);
         run_job(n, -1, "random");
      end
   endtask

   task automatic test_reset_mid();
      build_seq(40, 1);
      @(negedge clk);
      start = 1; num_lines = 40;
      for (int c = 1; c <= 57; c++) begin
         @(negedge clk);
         start = 0;
         cl_wr_valid = (sched[c] != 0);
         buffer_select = (sched[c] == 2);
      end
      checks++;
      if (issue_valid !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_run_before_reset: iv=%b busy=%b, expected 1 1", issue_valid, busy);
      end
      @(posedge clk);
      #2 reset = 1;
      #1;
      checks++;
      if ({rd_addr, issue_valid, res_wr_en, res_wr_addr, busy, done, stall_count} !== '0) begin
         failures++;
         $display("FAIL async_reset: rd=%0d iv=%b we=%b wa=%0d busy=%b done=%b stall=%0d, expected all 0",
                  rd_addr, issue_valid, res_wr_en, res_wr_addr, busy, done, stall_count);
      end
      @(negedge clk);
      idle_inputs();
      reset = 0;
      build_rand(256);
      run_job(256, -1, "full256");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_small();
      test_zero();
      test_abort();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
